// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: host byte stream in, instruction memory write port out
interface imem_boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    modport master (input rx_valid, rx_data, output rx_ready, mem_we, mem_addr, mem_wdata);
    modport slave (output rx_valid, rx_data, input rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed, checksummed byte stream into instruction memory and releases the core
module imem_boot_loader #(
    parameter int         DEPTH_WORDS = 64,
    parameter logic [7:0] MAGIC       = 8'hA5,
    parameter int         TIMEOUT     = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    imem_boot_loader_if.master         bus,
    output logic                       cpu_hold,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [7:0]                 words_loaded
);
    localparam int TW = $clog2(TIMEOUT + 2);
    typedef enum logic [2:0] {IDLE, WAIT_MAGIC, WAIT_COUNT, DATA, WRITE, WAIT_CSUM, RUN, ERROR} state_t;
    state_t        state, state_n;
    logic [7:0]    n, widx, csum;
    logic [1:0]    bidx;
    logic [23:0]   asm_w;
    logic [TW-1:0] tcnt;
    logic          acc, tmo, arm;
    always_comb begin
        acc = bus.rx_valid && bus.rx_ready;
        tmo = TIMEOUT != 0 && state inside {WAIT_COUNT, DATA, WAIT_CSUM} && !acc && int'(tcnt) == TIMEOUT - 1;
        state_n = state;
        case (state)
            WAIT_MAGIC: state_n = acc && bus.rx_data == MAGIC ? WAIT_COUNT : state;
            WAIT_COUNT: state_n = !acc ? state : bus.rx_data == 8'd0 || int'(bus.rx_data) > DEPTH_WORDS ? ERROR : DATA;
            DATA:       state_n = acc && bidx == 2'd3 ? WRITE : state;
            WRITE:      state_n = widx + 8'd1 == n ? WAIT_CSUM : DATA;
            WAIT_CSUM:  state_n = !acc ? state : bus.rx_data == csum ? RUN : ERROR;
            default:    state_n = start ? WAIT_MAGIC : state;
        endcase
        if (tmo) state_n = ERROR;
        arm = state_n == WAIT_MAGIC && state != WAIT_MAGIC;
    end
    // Outputs are registered from the next state so they always match the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cpu_hold      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'd0;
            words_loaded  <= 8'd0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            n             <= 8'd0;
            widx          <= 8'd0;
            csum          <= 8'd0;
            bidx          <= 2'd0;
            asm_w         <= 24'd0;
            tcnt          <= '0;
        end else begin
            state        <= state_n;
            bus.rx_ready <= state_n inside {WAIT_MAGIC, WAIT_COUNT, DATA, WAIT_CSUM};
            busy         <= state_n inside {WAIT_MAGIC, WAIT_COUNT, DATA, WRITE, WAIT_CSUM};
            cpu_hold     <= state_n != RUN;
            done         <= state_n == RUN;
            error        <= state_n == ERROR;
            bus.mem_we   <= state_n == WRITE;
            tcnt         <= acc || state_n != state ? '0 : tcnt + 1'b1;
            if (arm) begin
                err_code     <= 2'd0;
                words_loaded <= 8'd0;
            end
            if (state_n == ERROR && state != ERROR)
                err_code <= tmo ? 2'd3 : state == WAIT_COUNT ? 2'd1 : 2'd2;
            if (acc && state == WAIT_COUNT) begin
                n    <= bus.rx_data;
                widx <= 8'd0;
                bidx <= 2'd0;
                csum <= 8'd0;
            end
            // Bytes shift in from the top so byte 0 ends up in the least significant lane.
            if (acc && state == DATA) begin
                asm_w <= {bus.rx_data, asm_w[23:8]};
                csum  <= csum ^ bus.rx_data;
                bidx  <= bidx + 2'd1;
            end
            if (state_n == WRITE) begin
                bus.mem_addr  <= {22'd0, widx, 2'd0};
                bus.mem_wdata <= {bus.rx_data, asm_w};
            end
            if (state == WRITE) begin
                widx         <= widx + 8'd1;
                words_loaded <= words_loaded + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed frames with hand-computed expected writes and status
module tb_imem_boot_loader;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic cpu_hold, busy, done, error;
    logic [1:0] err_code;
    logic [7:0] words_loaded;
    int total = 0, bad = 0;
    logic [31:0] wa[$], wd[$];
    logic [7:0] fr[$];
    imem_boot_loader_if bus();
    imem_boot_loader #(.DEPTH_WORDS(64), .MAGIC(8'hA5), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .error(error), .err_code(err_code), .words_loaded(words_loaded));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.mem_we) begin
        wa.push_back(bus.mem_addr);
        wd.push_back(bus.mem_wdata);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic send(input logic [7:0] b);
        logic took = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        for (int k = 0; k < 50 && !took; k++) begin
            took = bus.rx_ready;
            tick();
        end
        bus.rx_valid = 1'b0;
        if (!took) check("send_stall", 32'(took), 32'd1);
    endtask
    task automatic send_all();
        foreach (fr[i]) send(fr[i]);
    endtask
    task automatic check_reset(input string tag);
        check(tag, {16'd0, cpu_hold, busy, done, error, err_code, words_loaded, bus.rx_ready, bus.mem_we}, 32'h8000);
        check({tag, "_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    endtask
    task automatic nominal(input string tag, input logic [7:0] cs);
        wa.delete();
        wd.delete();
        pulse_start();
        fr = '{8'hA5, 8'h02, 8'hB3, 8'h82, 8'h20, 8'h00, 8'h33, 8'h83, 8'h20, 8'h40, cs};
        send_all();
        check({tag, "_nwr"}, wa.size(), 2);
        check({tag, "_a1"}, wa[1], 32'd4);
        check({tag, "_d1"}, wd[1], 32'h40208333);
    endtask
    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();
        pulse_start();
        check("arm", {29'd0, busy, bus.rx_ready, cpu_hold}, 32'h7);
        fr = '{8'hA5, 8'h02, 8'hB3, 8'h82, 8'h20, 8'h00};
        send_all();
        check("lat_we", 32'(bus.mem_we), 32'd1);
        check("lat_addr", bus.mem_addr, 32'd0);
        check("lat_data", bus.mem_wdata, 32'h002082B3);
        check("write_not_ready", 32'(bus.rx_ready), 32'd0);
        tick();
        check("one_cycle_we", 32'(bus.mem_we), 32'd0);
        fr = '{8'h33, 8'h83, 8'h20, 8'h40, 8'hC1};
        send_all();
        check("nom_wr_total", wa.size(), 2);
        check("nom_a1", wa[1], 32'd4);
        check("nom_d1", wd[1], 32'h40208333);
        check("nom_status", {24'd0, done, cpu_hold, busy, error, 2'd0, err_code}, 32'h80);
        check("nom_words", 32'(words_loaded), 32'd2);
        wa.delete();
        wd.delete();
        pulse_start();
        check("rearm_hold", {30'd0, cpu_hold, done}, 32'h2);
        fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_all();
        check("noise_nwr", wa.size(), 1);
        check("noise_a0", wa[0], 32'd0);
        check("noise_d0", wd[0], 32'h00000013);
        check("noise_done", 32'(done), 32'd1);
        nominal("badcs", 8'hC0);
        check("badcs_d0", wd[0], 32'h002082B3);
        check("badcs_status", {24'd0, done, cpu_hold, error, 3'd0, err_code}, 32'h62);
        for (int r = 0; r < 2; r++) begin
            wa.delete();
            pulse_start();
            fr = '{8'hA5, r == 0 ? 8'h00 : 8'h41};
            send_all();
            repeat (2) tick();
            check(r == 0 ? "cnt0_code" : "cnt65_code", {30'd0, err_code}, 32'd1);
            check(r == 0 ? "cnt0_err" : "cnt65_err", 32'(error), 32'd1);
            check(r == 0 ? "cnt0_nwr" : "cnt65_nwr", wa.size(), 0);
        end
        begin
            int first_err = -1;
            pulse_start();
            fr = '{8'hA5, 8'h03, 8'h11, 8'h22};
            send_all();
            for (int k = 1; k <= 40 && first_err < 0; k++) begin
                tick();
                if (error) first_err = k;
            end
            check("tmo_latency", first_err, 20);
            check("tmo_code", {30'd0, err_code}, 32'd3);
            check("tmo_words", 32'(words_loaded), 32'd0);
        end
        wa.delete();
        pulse_start();
        fr = '{8'hA5, 8'h02, 8'hB3, 8'h82, 8'h20, 8'h00, 8'h33};
        send_all();
        #2 rst = 1'b1;
        #1 check_reset("midrst");
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("midrst_nwr", wa.size(), 1);
        nominal("restart", 8'hC1);
        check("restart_done", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_rearm", {30'd0, cpu_hold, done}, 32'h2);
        fr = '{8'hA5, 8'h02, 8'hB3, 8'h82, 8'h20, 8'h00, 8'h33, 8'h83, 8'h20, 8'h40, 8'hC1};
        wa.delete();
        wd.delete();
        send_all();
        check("reload_nwr", wa.size(), 2);
        check("reload_d0", wd[0], 32'h002082B3);
        check("reload_status", {30'd0, done, cpu_hold}, 32'h2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller that fills instruction memory from a byte stream (UART/debug link) before the core runs.
- Checks the framing, packs bytes into 32-bit little-endian words, and issues one write per word at the byte addresses the fetch unit uses (0, 4, 8, ...).
- Holds the core in reset until a load completes with a valid checksum.
- Sits between the host link receiver, the instruction memory write port and the core reset.

Parameters:
- DEPTH_WORDS, 64, maximum number of words per load; valid count range is 1..DEPTH_WORDS.
- MAGIC, 8'hA5, frame start byte.
- TIMEOUT, 1000, maximum cycles between accepted bytes once a frame has started; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that arms a load
- rx_valid  in  1  a byte is present on rx_data
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader can take a byte; a byte transfers in a cycle where rx_valid and rx_ready are both 1
- mem_we  out  1  instruction memory write strobe, high for one cycle per word
- mem_addr  out  32  byte address of the word being written, always word-aligned
- mem_wdata  out  32  word being written
- cpu_hold  out  1  holds the core in reset while 1
- busy  out  1  a load is in progress
- done  out  1  last load succeeded
- error  out  1  last load failed
- err_code  out  2  failure cause: 0 none, 1 bad count, 2 bad checksum, 3 timeout
- words_loaded  out  8  number of words written in the current or last load

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - cpu_hold=1.
  - All other outputs, the checksum, the counters and the assembly register clear to 0.
- Frame format: MAGIC, count N, then 4*N data bytes (least significant byte first), then a checksum byte equal to the XOR of all data bytes.
- All outputs are registered.
- IDLE:
  - rx_ready=0, cpu_hold=1.
  - start moves to WAIT_MAGIC and clears done, error, err_code and words_loaded.
- WAIT_MAGIC:
  - rx_ready=1, busy=1.
  - An accepted byte equal to MAGIC moves to WAIT_COUNT; any other byte is discarded and the state holds.
  - No timeout runs in this state.
- WAIT_COUNT:
  - Accepting N=0 or N>DEPTH_WORDS moves to ERROR with err_code=1.
  - Otherwise latch N, clear the byte index, word index and checksum, and move to DATA.
- DATA:
  - Accepted byte k (0..3) goes into assembly bits [8k+7:8k] and is XORed into the checksum.
  - On accepting byte 3, move to WRITE.
- WRITE (exactly one cycle, rx_ready=0):
  - mem_we=1, mem_addr = word_index*4, mem_wdata = the assembled word.
  - Then increment word_index and words_loaded.
  - If word_index now equals N, move to WAIT_CSUM; otherwise return to DATA.
  - Latency: the 4th byte accepted in cycle T produces mem_we in cycle T+1. The earliest next byte accept is T+2.
- WAIT_CSUM: an accepted byte equal to the checksum moves to RUN; a mismatch moves to ERROR with err_code=2.
- RUN:
  - cpu_hold=0, done=1, busy=0, rx_ready=0.
  - start re-arms: go to WAIT_MAGIC with cpu_hold=1 and done cleared in the same cycle as the transition.
- ERROR:
  - cpu_hold=1, error=1, busy=0, rx_ready=0.
  - start re-arms as in IDLE.
- Timeout:
  - In WAIT_COUNT, DATA and WAIT_CSUM, a counter clears on every accepted byte and on state entry.
  - When it reaches TIMEOUT, move to ERROR with err_code=3.
  - The counter is frozen in WRITE.
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last values outside WRITE.
- start is ignored while busy=1.
- Words already written before an error stay in memory; the loader never erases.
- Reset mid-load aborts immediately: no further writes, cpu_hold=1.
- rx_valid gaps: no data advances, and the timeout keeps counting.

Test Plan:
- Nominal load: start, then A5 02 B3 82 20 00 33 83 20 40 C1.
  - Required: writes of 0x002082B3 at address 0 and 0x40208333 at address 4.
  - Required: done=1, cpu_hold=0, words_loaded=2, and exactly 2 mem_we pulses.
- Noise before MAGIC: 00 FF 5A A5 01 13 00 00 00 13.
  - Required: the noise bytes are discarded and 0x00000013 is written at address 0.
  - Required: done=1.
- Bad checksum: the nominal frame with a final byte of C0.
  - Required: both words are written, then error=1, err_code=2, cpu_hold=1, done=0.
- Bad count: count byte 00 gives err_code=1; in a separate run, count byte 41 (65) gives err_code=1. Required: no mem_we in either run.
- Timeout with TIMEOUT=20: send A5 03 11 22, then idle.
  - Required: ERROR with err_code=3 exactly 20 cycles after the last accepted byte.
  - Required: words_loaded=0.
- Reset and restart:
  - Assert rst after 5 data bytes of the nominal frame. Required: all outputs at reset values, no further writes.
  - Then send start plus a full nominal frame. Required: done=1.
  - Then pulse start in RUN. Required: cpu_hold rises, then the next frame reloads successfully.
